// File: rtl/decoder_pkg.sv
// Shared mode encoding for the scanning one-hot decoder.
package decoder_pkg;

    typedef enum logic [1:0] {
        MODE_OFF       = 2'b00,
        MODE_DIRECT    = 2'b01,
        MODE_SCAN_UP   = 2'b10,
        MODE_SCAN_DOWN = 2'b11
    } mode_e;

endpackage

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot decoder with an all-zero enable gate.
module onehot_dec #(
    parameter int SEL_W = 4
) (
    input  logic [SEL_W-1:0]    sel,
    input  logic                en,
    output logic [2**SEL_W-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < 2**SEL_W; i++) begin
            onehot[i] = en && (sel == SEL_W'(i));
        end
    end

endmodule

// File: rtl/decoder_scan.sv
// One-hot decoder with direct select and dwell-timed up/down scanning.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W = 4,
    parameter int DWELL = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [SEL_W-1:0]    sel_in,
    input  logic                load,
    output logic [2**SEL_W-1:0] d,
    output logic [SEL_W-1:0]    cur_sel,
    output logic                out_valid,
    output logic                wrap
);

    localparam int OUT_W = 2**SEL_W;
    localparam int CNT_W = $clog2(DWELL + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    mode_e            mode_q;
    logic [SEL_W-1:0] pos;
    logic [SEL_W-1:0] pos_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             in_scan;
    logic             in_scan_nxt;
    logic             valid_nxt;
    logic             wrap_nxt;
    logic [OUT_W-1:0] d_nxt;

    assign mode_q  = mode_e'(mode);
    assign cur_sel = pos;

    // in_scan marks that the previous enabled cycle was already scanning,
    // so the first scan cycle after any other mode only presents pos.
    always_comb begin
        pos_nxt     = pos;
        cnt_nxt     = cnt;
        in_scan_nxt = in_scan;
        valid_nxt   = 1'b0;
        wrap_nxt    = 1'b0;
        if (en) begin
            unique case (mode_q)
                MODE_OFF: begin
                    in_scan_nxt = 1'b0;
                end
                MODE_DIRECT: begin
                    pos_nxt     = sel_in;
                    cnt_nxt     = '0;
                    in_scan_nxt = 1'b0;
                    valid_nxt   = 1'b1;
                end
                MODE_SCAN_UP, MODE_SCAN_DOWN: begin
                    valid_nxt   = 1'b1;
                    in_scan_nxt = 1'b1;
                    if (load) begin
                        pos_nxt = sel_in;
                        cnt_nxt = '0;
                    end else if (!in_scan) begin
                        cnt_nxt = '0;
                    end else if (cnt == CNT_LAST) begin
                        cnt_nxt = '0;
                        if (mode_q == MODE_SCAN_UP) begin
                            pos_nxt  = pos + 1'b1;
                            wrap_nxt = (pos == '1);
                        end else begin
                            pos_nxt  = pos - 1'b1;
                            wrap_nxt = (pos == '0);
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    in_scan_nxt = 1'b0;
                end
            endcase
        end
    end

    onehot_dec #(
        .SEL_W(SEL_W)
    ) u_dec (
        .sel   (pos_nxt),
        .en    (valid_nxt),
        .onehot(d_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pos       <= '0;
            cnt       <= '0;
            in_scan   <= 1'b0;
            d         <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            pos       <= pos_nxt;
            cnt       <= cnt_nxt;
            in_scan   <= in_scan_nxt;
            d         <= d_nxt;
            out_valid <= valid_nxt;
            wrap      <= wrap_nxt;
        end
    end

endmodule
